// File: rtl/decereal.sv
// decereal: 8N1 serial receiver, companion to the cereal transmitter.
// Oversamples rx on each tick, samples mid-bit and presents each good byte
// on data with a one-cycle valid strobe. A low stop bit raises frame_err
// and the receiver parks until the line goes high again.
// Optional macro DECEREAL_SYNC_EN: adds a two-flop synchronizer on rx.
module decereal #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic [CW-1:0]   tcnt;
    logic [2:0]      bcnt;
    logic [7:0]      shreg;
    logic            rxs;

`ifdef DECEREAL_SYNC_EN
    logic [1:0] sync_reg;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rxs = sync_reg[1];
`else
    assign rxs = rx;
`endif

    // Receive FSM: advances only on tick edges; strobes clear every clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rxs) begin
                            state <= S_START;
                            tcnt  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (tcnt == HALF_LAST) begin
                            if (rxs) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_DATA;
                                tcnt  <= '0;
                                bcnt  <= '0;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tcnt == FULL_LAST) begin
                            tcnt  <= '0;
                            shreg <= {rxs, shreg[7:1]};
                            if (bcnt == 3'd7) begin
                                state <= S_STOP;
                            end else begin
                                bcnt <= bcnt + 3'd1;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tcnt == FULL_LAST) begin
                            tcnt <= '0;
                            if (rxs) begin
                                data  <= shreg;
                                valid <= 1'b1;
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_BREAK: begin
                        if (rxs) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decereal.sv
// tb_decereal: directed self-checking bench for the decereal receiver.
// Frames are driven at 16 clk per bit with tick every clk, except one
// scenario with tick every 4th clk. A negedge monitor records every
// valid / frame_err cycle so each scenario can check counts and values.
module tb_decereal;

`ifdef DECEREAL_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int EXP_LAT = 153 + SYNC_DLY;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    int tick_period = 1;
    int tick_phase  = 0;

    int         cyc      = 0;
    int         v_cnt    = 0;
    int         e_cnt    = 0;
    int         both_cnt = 0;
    logic [7:0] v_data[$];
    int         v_cyc[$];

    decereal #(.OVERSAMPLE(16)) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .rx(rx),
        .data(data),
        .valid(valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    // Tick strobe, updated on the falling edge so it is stable at posedge
    initial begin
        tick = 1'b1;
        forever begin
            @(negedge clk);
            tick_phase = (tick_phase + 1) % tick_period;
            tick = (tick_phase == 0);
        end
    end

    // Output monitor: logs every cycle in which a strobe is high
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid) begin
            v_cnt = v_cnt + 1;
            v_data.push_back(data);
            v_cyc.push_back(cyc);
        end
        if (frame_err) e_cnt = e_cnt + 1;
        if (valid && frame_err) both_cnt = both_cnt + 1;
    end

    // Hard stop in case something never terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb);
        rx = 1'b0;
        wait_clk(cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(cpb);
        end
        rx = stop_bit;
        wait_clk(cpb);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(3);
        n_cmp++;
        if (data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected 00", data);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_valid: got %b expected 0", valid);
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        rst = 1'b0;
        wait_clk(4);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_byte();
        int lat;
        int vb;
        int eb;
        lat = 0;
        vb  = v_cnt;
        eb  = e_cnt;
        fork
            send_frame(8'hA5, 1'b1, 16);
            begin
                for (int k = 1; k <= 400; k++) begin
                    wait_clk(1);
                    if (valid) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        rx = 1'b1;
        wait_clk(10);
        n_cmp++;
        if (lat !== EXP_LAT) begin
            n_fail++;
            $display("[TB] FAIL single_latency: got %0d expected %0d (0 = timeout)", lat, EXP_LAT);
        end
        n_cmp++;
        if (v_cnt - vb !== 1) begin
            n_fail++;
            $display("[TB] FAIL single_valid_cycles: got %0d expected 1", v_cnt - vb);
        end
        n_cmp++;
        if (data !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL single_data: got %h expected a5", data);
        end
        n_cmp++;
        if (e_cnt - eb !== 0) begin
            n_fail++;
            $display("[TB] FAIL single_frame_err: got %0d expected 0", e_cnt - eb);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        int base;
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h3C;
        base = v_data.size();
        for (int i = 0; i < 3; i++) begin
            send_frame(exp_b[i], 1'b1, 16);
        end
        rx = 1'b1;
        wait_clk(20);
        n_cmp++;
        if (v_data.size() - base !== 3) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got %0d expected 3", v_data.size() - base);
        end
        if (v_data.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (v_data[base + i] !== exp_b[i]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, v_data[base + i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (v_cyc[base + i] - v_cyc[base + i - 1] !== 160) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_spacing%0d: got %0d expected 160", i,
                             v_cyc[base + i] - v_cyc[base + i - 1]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int bc;
        int vb;
        int eb;
        bc = 0;
        vb = v_cnt;
        eb = e_cnt;
        rx = 1'b0;
        for (int i = 0; i < 24; i++) begin
            wait_clk(1);
            if (busy) bc++;
            if (i == 3) rx = 1'b1;
        end
        n_cmp++;
        if (bc !== 8) begin
            n_fail++;
            $display("[TB] FAIL glitch_busy_cycles: got %0d expected 8", bc);
        end
        n_cmp++;
        if (v_cnt - vb !== 0) begin
            n_fail++;
            $display("[TB] FAIL glitch_valid: got %0d expected 0", v_cnt - vb);
        end
        n_cmp++;
        if (e_cnt - eb !== 0) begin
            n_fail++;
            $display("[TB] FAIL glitch_frame_err: got %0d expected 0", e_cnt - eb);
        end
    endtask

    task automatic test_frame_error();
        int vb;
        int eb;
        int low_cnt;
        vb      = v_cnt;
        eb      = e_cnt;
        low_cnt = 0;
        send_frame(8'h5A, 1'b0, 16);
        for (int i = 0; i < 24; i++) begin
            wait_clk(1);
            if (!busy) low_cnt++;
        end
        n_cmp++;
        if (e_cnt - eb !== 1) begin
            n_fail++;
            $display("[TB] FAIL ferr_pulses: got %0d expected 1", e_cnt - eb);
        end
        n_cmp++;
        if (data !== 8'h3C) begin
            n_fail++;
            $display("[TB] FAIL ferr_data_hold: got %h expected 3c", data);
        end
        n_cmp++;
        if (low_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL ferr_busy_held: got %0d idle cycles expected 0", low_cnt);
        end
        rx = 1'b1;
        wait_clk(1 + SYNC_DLY);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ferr_busy_release: got %b expected 0", busy);
        end
        wait_clk(200);
        n_cmp++;
        if (v_cnt - vb !== 0) begin
            n_fail++;
            $display("[TB] FAIL ferr_valid: got %0d expected 0", v_cnt - vb);
        end
        n_cmp++;
        if (e_cnt - eb !== 1) begin
            n_fail++;
            $display("[TB] FAIL ferr_no_retrigger: got %0d expected 1", e_cnt - eb);
        end
    endtask

    task automatic test_slow_tick();
        int  vb;
        int  eb;
        int  bc;
        logic found;
        vb    = v_cnt;
        eb    = e_cnt;
        bc    = 0;
        found = 1'b0;
        tick_period = 4;
        for (int i = 0; i < 12 && !found; i++) begin
            wait_clk(1);
            if (tick) found = 1'b1;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL slow_tick_seen: got %b expected 1", found);
        end
        // One-clk low pulse that falls between ticks must be ignored
        rx = 1'b0;
        wait_clk(1);
        rx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_clk(1);
            if (busy) bc++;
        end
        n_cmp++;
        if (bc !== 0) begin
            n_fail++;
            $display("[TB] FAIL slow_offtick_ignored: got %0d busy cycles expected 0", bc);
        end
        send_frame(8'h81, 1'b1, 64);
        rx = 1'b1;
        wait_clk(20);
        n_cmp++;
        if (v_cnt - vb !== 1) begin
            n_fail++;
            $display("[TB] FAIL slow_valid_cycles: got %0d expected 1", v_cnt - vb);
        end
        n_cmp++;
        if (data !== 8'h81) begin
            n_fail++;
            $display("[TB] FAIL slow_data: got %h expected 81", data);
        end
        n_cmp++;
        if (e_cnt - eb !== 0) begin
            n_fail++;
            $display("[TB] FAIL slow_frame_err: got %0d expected 0", e_cnt - eb);
        end
        tick_period = 1;
        wait_clk(8);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int vb;
        int eb;
        b  = 8'hB7;
        vb = v_cnt;
        eb = e_cnt;
        rx = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            wait_clk(16);
        end
        rx = b[3];
        wait_clk(8);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midrst_data: got %h expected 00", data);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_busy: got %b expected 0", busy);
        end
        n_cmp++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_strobes: got valid=%b frame_err=%b expected 0 0", valid, frame_err);
        end
        rx = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        send_frame(8'h42, 1'b1, 16);
        rx = 1'b1;
        wait_clk(20);
        n_cmp++;
        if (v_cnt - vb !== 1) begin
            n_fail++;
            $display("[TB] FAIL midrst_next_valid: got %0d expected 1", v_cnt - vb);
        end
        n_cmp++;
        if (data !== 8'h42) begin
            n_fail++;
            $display("[TB] FAIL midrst_next_data: got %h expected 42", data);
        end
        n_cmp++;
        if (e_cnt - eb !== 0) begin
            n_fail++;
            $display("[TB] FAIL midrst_frame_err: got %0d expected 0", e_cnt - eb);
        end
    endtask

    initial begin
        $display("[TB] decereal bench start");
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_slow_tick();
        test_reset_mid_frame();
        n_cmp++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL strobes_exclusive: got %0d overlapping cycles expected 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
